alu_2bits: RTL and testbench

//   Registered 2-bit ALU: tiny-tapeout style user tile. Two 2-bit operands and
//   a 4-bit opcode on ui_in. 4-bit result plus zero/carry/overflow/parity flags
//   on uo_out, registered one cycle after capture. Bidirectional pins unused.

---
 rtl/alu_2bits.sv | 99 +++++++++
 tb/tb_alu_2bits.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/alu_2bits.sv
// Registered 2-bit ALU tile. ui_in={OP,B,A}; uo_out={P,V,C,Z,R}.
// Ports: clk, rst_n (active-high async reset), ena, ui_in, uo_out,
//        uio_in (ignored), uio_out/uio_oe (tied low).
module alu_2bits (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [1:0] a;
    logic [1:0] b;
    logic [3:0] op;
    logic [2:0] sum;
    logic [2:0] diff;
    logic [3:0] prod;
    logic [3:0] r;
    logic       c;
    logic       v;
    logic       z;
    logic       p;
    logic       unused_ok;

    assign a  = ui_in[1:0];
    assign b  = ui_in[3:2];
    assign op = ui_in[7:4];

    // diff[2] is the borrow out of the 2-bit subtraction
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    assign prod = {2'b00, a} * {2'b00, b};

    always_comb begin
        r = 4'h0;
        c = 1'b0;
        v = 1'b0;
        unique case (op)
            4'd0: begin
                r = {1'b0, sum};
                c = sum[2];
                v = (a[1] == b[1]) && (sum[1] != a[1]);
            end
            4'd1: begin
                r = {2'b00, diff[1:0]};
                c = diff[2];
                v = (a[1] != b[1]) && (diff[1] != a[1]);
            end
            4'd2:  r = {2'b00, a & b};
            4'd3:  r = {2'b00, a | b};
            4'd4:  r = {2'b00, a ^ b};
            4'd5:  r = {2'b00, ~(a & b)};
            4'd6:  r = {2'b00, ~(a | b)};
            4'd7:  r = {2'b00, ~(a ^ b)};
            4'd8:  r = {2'b00, ~a};
            4'd9: begin
                r = {2'b00, a[0], 1'b0};
                c = a[1];
            end
            4'd10: begin
                r = {3'b000, a[1]};
                c = a[0];
            end
            4'd11: r = prod;
            4'd12: begin
                r = {2'b00, a + 2'd1};
                c = (a == 2'd3);
                v = (a == 2'b01);
            end
            4'd13: begin
                r = {2'b00, a - 2'd1};
                c = (a == 2'd0);
                v = (a == 2'b10);
            end
            4'd14: r = {1'b0, a > b, a == b, a < b};
            4'd15: r = {b, a};
            default: r = 4'h0;
        endcase
    end

    assign z = (r == 4'h0);
    assign p = ^r;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            uo_out <= 8'h00;
        end else if (ena) begin
            uo_out <= {p, v, c, z, r};
        end
    end

    assign uio_out   = 8'h00;
    assign uio_oe    = 8'h00;
    assign unused_ok = ^uio_in;

endmodule

// File: tb/tb_alu_2bits.sv
// Self-checking bench for alu_2bits: directed vectors, full sweep,
// randomized ena/ui_in traffic and mid-run asynchronous reset.
module tb_alu_2bits;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int errors;
    int checks;
    logic [7:0] held;

    alu_2bits dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // signed 2-bit value of an unsigned 0..3
    function automatic int sgn(int x);
        return (x >= 2) ? x - 4 : x;
    endfunction

    function automatic logic [7:0] model(logic [7:0] ui);
        int a, b, op, r, c, v, s;
        logic [3:0] rr;
        logic z, p;
        a = int'(ui[1:0]);
        b = int'(ui[3:2]);
        op = int'(ui[7:4]);
        r = 0; c = 0; v = 0;
        case (op)
            0: begin
                r = a + b; c = (r > 3) ? 1 : 0;
                s = sgn(a) + sgn(b);
                v = (s < -2 || s > 1) ? 1 : 0;
            end
            1: begin
                r = (a - b + 4) % 4; c = (a < b) ? 1 : 0;
                s = sgn(a) - sgn(b);
                v = (s < -2 || s > 1) ? 1 : 0;
            end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 3 - (a & b);
            6: r = 3 - (a | b);
            7: r = 3 - (a ^ b);
            8: r = 3 - a;
            9: begin r = (a * 2) % 4; c = a / 2; end
            10: begin r = a / 2; c = a % 2; end
            11: r = a * b;
            12: begin
                r = (a + 1) % 4; c = (a == 3) ? 1 : 0;
                v = (sgn(a) + 1 > 1) ? 1 : 0;
            end
            13: begin
                r = (a + 3) % 4; c = (a == 0) ? 1 : 0;
                v = (sgn(a) - 1 < -2) ? 1 : 0;
            end
            14: r = ((a > b) ? 4 : 0) + ((a == b) ? 2 : 0)
                  + ((a < b) ? 1 : 0);
            default: r = b * 4 + a;
        endcase
        rr = r[3:0];
        z = (r == 0);
        p = ^rr;
        return {p, v[0], c[0], z, rr};
    endfunction

    task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // drive on the falling edge, sample 1 time unit after the rising edge
    task automatic step(logic [7:0] ui, logic en);
        @(negedge clk);
        ui_in = ui;
        ena = en;
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        ena = 1'b0;
        ui_in = 8'h0B;
        uio_in = 8'hA5;
        held = 8'h00;

        #1 rst_n = 1'b1;
        #1;
        chk("reset_uo_out", uo_out, 8'h00);
        chk("reset_uio_out", uio_out, 8'h00);
        chk("reset_uio_oe", uio_oe, 8'h00);

        step(8'h0B, 1'b1);
        chk("reset_held_on_edge", uo_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b0;

        step(8'h0B, 1'b1);
        chk("add_3_2", uo_out, 8'h65);
        step(8'h19, 1'b1);
        chk("sub_1_2", uo_out, 8'h63);
        step(8'hBF, 1'b1);
        chk("mul_3_3", uo_out, 8'h09);
        step(8'h4A, 1'b1);
        chk("xor_2_2", uo_out, 8'h10);
        step(8'hE9, 1'b1);
        chk("cmp_1_2", uo_out, 8'h81);
        step(8'h0B, 1'b0);
        chk("ena_hold", uo_out, 8'h81);
        step(8'h0B, 1'b0);
        chk("ena_hold2", uo_out, 8'h81);

        for (int i = 0; i < 1024; i++) begin
            step(i[7:0], 1'b1);
            chk($sformatf("sweep_%0d", i), uo_out, model(i[7:0]));
            if (i == 512) begin
                #2 rst_n = 1'b1;
                #1;
                chk("mid_reset_async", uo_out, 8'h00);
                step(8'hFF, 1'b1);
                chk("mid_reset_hold", uo_out, 8'h00);
                @(negedge clk);
                rst_n = 1'b0;
            end
        end

        held = uo_out;
        for (int k = 0; k < 300; k++) begin
            logic [7:0] u;
            logic e;
            u = 8'($urandom);
            e = ($urandom_range(0, 3) != 0);
            uio_in = 8'($urandom);
            step(u, e);
            if (e) held = model(u);
            chk($sformatf("rand_%0d", k), uo_out, held);
            chk($sformatf("rand_uio_%0d", k), {uio_out | uio_oe}, 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
